sync_fifo_flags: RTL

Single-clock, parametrised FIFO buffer; next-generation replacement for the team's fixed 4-bit FIFO. Generalised in data width and depth. Adds occupancy count, full/empty flags, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in the same clock domain.

---
 rtl/sync_fifo_flags_if.sv | 28 ++
 rtl/sync_fifo_flags.sv | 90 +++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags.
// The FIFO takes the slave side; the surrounding logic takes the master side.
interface sync_fifo_flags_if #(
  parameter int data_width = 4,
  parameter int addr_width = 4
);
  logic [data_width-1:0] fifo_in;
  logic                  we;
  logic                  re;
  logic [data_width-1:0] fifo_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [addr_width:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output fifo_in, we, re,
    input  fifo_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  fifo_in, we, re,
    output fifo_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock parametrised FIFO with occupancy count, full/empty and programmable
// almost flags, overflow/underflow pulses and optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int data_width = 4,
  parameter int addr_width = 4,
  parameter int af_thresh  = 14,
  parameter int ae_thresh  = 2,
  parameter int fwft       = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 1 << addr_width;
  localparam logic [addr_width:0] DEPTH_C = (addr_width+1)'(DEPTH);
  localparam logic [addr_width:0] AF_C    = (addr_width+1)'(af_thresh);
  localparam logic [addr_width:0] AE_C    = (addr_width+1)'(ae_thresh);

  if (af_thresh < 1 || af_thresh > DEPTH || ae_thresh < 0 || ae_thresh >= DEPTH) begin : g_bad_params
    $fatal(1, "sync_fifo_flags: af_thresh must be 1..DEPTH and ae_thresh 0..DEPTH-1");
  end

  logic [data_width-1:0] mem_q [DEPTH];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic                  wr_ok_s, rd_ok_s;

  // Accept decisions, next pointers/count and registered-mode read data.
  always_comb begin
    rd_ok_s  = bus.re && !empty_q;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_ok_s  = bus.we && (!full_q || rd_ok_s);
    wr_ptr_d = wr_ok_s ? wr_ptr_q + addr_width'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok_s ? rd_ptr_q + addr_width'(1) : rd_ptr_q;
    count_d  = count_q + (addr_width+1)'(wr_ok_s) - (addr_width+1)'(rd_ok_s);
    rdata_d  = rdata_q;
    if (fwft == 0 && rd_ok_s) begin
      rdata_d = mem_q[rd_ptr_q];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Pointer, count and flag registers; flags come from the next count so they carry no lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_C);
      ae_q     <= (count_d <= AE_C);
      ovf_q    <= bus.we && !wr_ok_s;
      unf_q    <= bus.re && !rd_ok_s;
    end
  end

  // Storage array; never cleared, and reset blocks a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) begin
      mem_q[wr_ptr_q] <= bus.fifo_in;
    end
  end

  // In fall-through mode the head word is presented straight from the array.
  assign bus.fifo_out     = (fwft != 0) ? mem_q[rd_ptr_q] : rdata_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
